// File: rtl/pong_tx_scheduler.sv
// pong_tx_scheduler
//   Round-robin arbiter and packet framer for the pong link UART transmit
//   path. Game-state producers each offer a 16-bit word. One word is granted
//   at a time and sent to the UART TX FIFO as a 4-byte packet:
//      {4'hA, 2'b00, id}, word[15:8], word[7:0], and the XOR of those three bytes.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           allows new grants (a frame already started always completes)
//   req_valid    per-requester word valid
//   req_data     requester i's word at [16*i+15:16*i]
//   req_ready    one-hot acceptance pulse (accepted on req_valid & req_ready)
//   tx_full      UART TX FIFO full
//   tx_wr        FIFO write strobe
//   tx_data      byte being written
//   busy         high while a frame is being sent
//   frame_done   one-cycle pulse in the cycle after the last byte is written
module pong_tx_scheduler #(
   parameter int N_REQ = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*16-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                tx_full,
   output logic                tx_wr,
   output logic [7:0]          tx_data,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      HI   = 3'd2,
      LO   = 3'd3,
      CHK  = 3'd4
   } state_t;

   localparam logic [1:0] LAST_ID = 2'(N_REQ - 1);

   state_t        state_reg;
   state_t        state_next;
   logic [1:0]    rr_ptr_reg;
   logic [1:0]    id_reg;
   logic [15:0]   word_reg;
   logic          frame_done_reg;

   logic          grant_found;
   logic [1:0]    grant_id;
   logic [15:0]   grant_word;
   logic          grant_en;
   logic [7:0]    hdr_byte;
   logic [7:0]    chk_byte;

   // Round-robin search starting at rr_ptr. Shifts are used instead of
   // variable part-selects so the index width never depends on N_REQ.
   always_comb begin
      logic [N_REQ-1:0]    valid_sh;
      logic [N_REQ*16-1:0] data_sh;
      int                  idx;
      grant_found = 1'b0;
      grant_id    = 2'd0;
      grant_word  = 16'h0000;
      valid_sh    = '0;
      data_sh     = '0;
      idx         = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         valid_sh = req_valid >> idx;
         data_sh  = req_data >> (16 * idx);
         if (!grant_found && valid_sh[0]) begin
            grant_found = 1'b1;
            grant_id    = 2'(idx);
            grant_word  = data_sh[15:0];
         end
      end
   end

   // The grant is taken in the IDLE cycle itself; the id and word are
   // captured on the clock edge that closes that cycle. Gating with rst_n
   // keeps req_ready low for the whole time reset is held.
   assign grant_en = (state_reg == IDLE) && en && grant_found && rst_n;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign req_ready[gi] = grant_en && (grant_id == 2'(gi));
      end
   endgenerate

   assign hdr_byte = {4'hA, 2'b00, id_reg};
   assign chk_byte = hdr_byte ^ word_reg[15:8] ^ word_reg[7:0];

   // Next state and byte outputs. A send state advances only when its byte
   // is actually written, so every full cycle adds exactly one cycle.
   always_comb begin
      state_next = state_reg;
      tx_wr      = 1'b0;
      tx_data    = 8'h00;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_en) begin
               state_next = HDR;
            end
         end
         HDR: begin
            busy    = 1'b1;
            tx_data = hdr_byte;
            tx_wr   = !tx_full;
            if (!tx_full) begin
               state_next = HI;
            end
         end
         HI: begin
            busy    = 1'b1;
            tx_data = word_reg[15:8];
            tx_wr   = !tx_full;
            if (!tx_full) begin
               state_next = LO;
            end
         end
         LO: begin
            busy    = 1'b1;
            tx_data = word_reg[7:0];
            tx_wr   = !tx_full;
            if (!tx_full) begin
               state_next = CHK;
            end
         end
         CHK: begin
            busy    = 1'b1;
            tx_data = chk_byte;
            tx_wr   = !tx_full;
            if (!tx_full) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         rr_ptr_reg     <= 2'd0;
         id_reg         <= 2'd0;
         word_reg       <= 16'h0000;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         frame_done_reg <= (state_reg == CHK) && tx_wr;
         if (grant_en) begin
            id_reg     <= grant_id;
            word_reg   <= grant_word;
            // With a single requester LAST_ID is 0, so the pointer stays 0.
            rr_ptr_reg <= (grant_id == LAST_ID) ? 2'd0 : grant_id + 2'd1;
         end
      end
   end

   assign frame_done = frame_done_reg;

endmodule
